// File: rtl/barrel_pkg.sv
// Shared types for the pipelined barrel shifter/rotator.
// Optional carry output is controlled by the BARREL_CARRY_OUT_EN macro in the users of this package.
package barrel_pkg;

    // Operation selected per beat; the reserved code behaves as a logical shift.
    typedef enum logic [1:0] {
        MODE_ROT = 2'b00,
        MODE_LSH = 2'b01,
        MODE_ASH = 2'b10,
        MODE_RSV = 2'b11
    } barrel_mode_e;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    // Control fields that travel with every beat through the pipeline.
    typedef struct packed {
        logic         dir;
        barrel_mode_e mode;
    } barrel_ctrl_t;

endpackage

// File: rtl/barrel_stage.sv
// One pipeline stage: conditional shift/rotate by 2^K plus payload/valid register.
// With BARREL_CARRY_OUT_EN defined, a carry bit is carried alongside the data.
module barrel_stage
    import barrel_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = 3,
    parameter int K     = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             dir_i,
    input  barrel_mode_e     mode_i,
`ifdef BARREL_CARRY_OUT_EN
    input  logic             carry_i,
    output logic             carry_o,
`endif
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             dir_o,
    output barrel_mode_e     mode_o,
    input  logic [SHW-1:0]   amt_i,
    output logic [SHW-1:0]   amt_o
);

    localparam int S = 1 << K;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        barrel_ctrl_t     ctrl;
        logic [SHW-1:0]   amt;
`ifdef BARREL_CARRY_OUT_EN
        logic             carry;
`endif
    } payload_t;

    logic [WIDTH-1:0] shifted_s;
    payload_t         pay_d;
    payload_t         pay_q;
    logic             valid_d;
    logic             valid_q;

    // Shift or rotate by 2^K when this stage's amount bit is set, else pass through.
    always_comb begin
        shifted_s = data_i;
        if (amt_i[K]) begin
            if (dir_i == DIR_LEFT) begin
                case (mode_i)
                    MODE_ROT: shifted_s = {data_i[WIDTH-S-1:0], data_i[WIDTH-1:WIDTH-S]};
                    default:  shifted_s = {data_i[WIDTH-S-1:0], {S{1'b0}}};
                endcase
            end else begin
                case (mode_i)
                    MODE_ROT: shifted_s = {data_i[S-1:0], data_i[WIDTH-1:S]};
                    MODE_ASH: shifted_s = {{S{data_i[WIDTH-1]}}, data_i[WIDTH-1:S]};
                    default:  shifted_s = {{S{1'b0}}, data_i[WIDTH-1:S]};
                endcase
            end
        end else begin
            shifted_s = data_i;
        end
    end

    // Assemble the payload to be captured by this stage.
    always_comb begin
        pay_d.data      = shifted_s;
        pay_d.ctrl.dir  = dir_i;
        pay_d.ctrl.mode = mode_i;
        pay_d.amt       = amt_i;
`ifdef BARREL_CARRY_OUT_EN
        pay_d.carry     = carry_i;
`endif
        valid_d         = valid_i;
    end

    // Stage register: advances only when the whole pipeline advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pay_q   <= '0;
        end else if (en_i) begin
            valid_q <= valid_d;
            pay_q   <= pay_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = pay_q.data;
    assign dir_o   = pay_q.ctrl.dir;
    assign mode_o  = pay_q.ctrl.mode;
    assign amt_o   = pay_q.amt;
`ifdef BARREL_CARRY_OUT_EN
    assign carry_o = pay_q.carry;
`endif

endmodule

// File: rtl/barrel_rotator_pipe.sv
// Pipelined barrel shifter/rotator with valid/ready handshake, one log2 stage per register.
// Define BARREL_CARRY_OUT_EN to add the out_carry port (last bit shifted out).
module barrel_rotator_pipe
    import barrel_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic             in_dir,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef BARREL_CARRY_OUT_EN
    ,
    output logic             out_carry
`endif
);

    localparam logic [SHW-1:0] AMT_ZERO = '0;
    localparam logic [SHW-1:0] AMT_ONE  = SHW'(1);

    logic             adv_s;
    logic             stg_valid_in_s  [SHW];
    logic             stg_valid_out_s [SHW];
    logic [WIDTH-1:0] stg_data_in_s   [SHW];
    logic [WIDTH-1:0] stg_data_out_s  [SHW];
    logic             stg_dir_in_s    [SHW];
    logic             stg_dir_out_s   [SHW];
    barrel_mode_e     stg_mode_in_s   [SHW];
    barrel_mode_e     stg_mode_out_s  [SHW];
    logic [SHW-1:0]   stg_amt_in_s    [SHW];
    logic [SHW-1:0]   stg_amt_out_s   [SHW];
`ifdef BARREL_CARRY_OUT_EN
    logic             stg_carry_in_s  [SHW];
    logic             stg_carry_out_s [SHW];
    logic [SHW-1:0]   carry_idx_s;
    logic             carry_first_s;

    // Select the last bit that leaves the word, taken from the original input.
    always_comb begin
        carry_idx_s   = AMT_ZERO;
        carry_first_s = 1'b0;
        if (in_amt == AMT_ZERO) begin
            carry_first_s = 1'b0;
        end else begin
            if (in_dir == DIR_LEFT) begin
                carry_idx_s = AMT_ZERO - in_amt;
            end else begin
                carry_idx_s = in_amt - AMT_ONE;
            end
            carry_first_s = in_data[carry_idx_s];
        end
    end
`endif

    // Whole pipeline moves together whenever the output slot is free or being drained.
    assign adv_s    = out_ready | ~out_valid;
    assign in_ready = adv_s;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign stg_valid_in_s[k] = in_valid;
            assign stg_data_in_s[k]  = in_data;
            assign stg_dir_in_s[k]   = in_dir;
            assign stg_mode_in_s[k]  = barrel_mode_e'(in_mode);
            assign stg_amt_in_s[k]   = in_amt;
`ifdef BARREL_CARRY_OUT_EN
            assign stg_carry_in_s[k] = carry_first_s;
`endif
        end else begin : g_link
            assign stg_valid_in_s[k] = stg_valid_out_s[k-1];
            assign stg_data_in_s[k]  = stg_data_out_s[k-1];
            assign stg_dir_in_s[k]   = stg_dir_out_s[k-1];
            assign stg_mode_in_s[k]  = stg_mode_out_s[k-1];
            assign stg_amt_in_s[k]   = stg_amt_out_s[k-1];
`ifdef BARREL_CARRY_OUT_EN
            assign stg_carry_in_s[k] = stg_carry_out_s[k-1];
`endif
        end

        barrel_stage #(
            .WIDTH (WIDTH),
            .SHW   (SHW),
            .K     (k)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .en_i    (adv_s),
            .valid_i (stg_valid_in_s[k]),
            .data_i  (stg_data_in_s[k]),
            .dir_i   (stg_dir_in_s[k]),
            .mode_i  (stg_mode_in_s[k]),
`ifdef BARREL_CARRY_OUT_EN
            .carry_i (stg_carry_in_s[k]),
            .carry_o (stg_carry_out_s[k]),
`endif
            .valid_o (stg_valid_out_s[k]),
            .data_o  (stg_data_out_s[k]),
            .dir_o   (stg_dir_out_s[k]),
            .mode_o  (stg_mode_out_s[k]),
            .amt_i   (stg_amt_in_s[k]),
            .amt_o   (stg_amt_out_s[k])
        );
    end

    // Outputs come straight from the last stage register.
    assign out_valid = stg_valid_out_s[SHW-1];
    assign out_data  = stg_data_out_s[SHW-1];
`ifdef BARREL_CARRY_OUT_EN
    assign out_carry = stg_carry_out_s[SHW-1];
`endif

    // Control fields of the final stage have no consumer beyond the pipeline.
    logic unused_tail_s;
    assign unused_tail_s = ^{stg_dir_out_s[SHW-1], stg_mode_out_s[SHW-1], stg_amt_out_s[SHW-1]};

endmodule
